// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control sequencer for the stopwatch datapath: debounces the four user
//   buttons, runs the IDLE/RUN/PAUSE state machine, generates the count tick
//   and drives the BCD counter, lap register and display select.
//
// Ports:
//   CLK, RST_N          system clock, asynchronous active-low reset
//   btn_start/stop/lap/clear  raw active-high buttons (asynchronous to CLK)
//   count_at_max        BCD counter currently holds 8'h99
//   count_en            one-cycle increment strobe to the BCD counter
//   count_clear         one-cycle clear strobe to the BCD counter
//   lap_capture         one-cycle strobe to latch the counter into the lap register
//   show_lap            display select: 1 = lap register, 0 = live count
//   running             high in RUN
//   state               00 IDLE, 01 RUN, 10 PAUSE
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 1200000,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LAP_HOLD_CYCLES = 24000000,
    parameter int STOP_AT_MAX     = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       count_at_max,
    output logic       count_en,
    output logic       count_clear,
    output logic       lap_capture,
    output logic       show_lap,
    output logic       running,
    output logic [1:0] state
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Hold counter must be able to hold LAP_HOLD_CYCLES itself, not just count below it.
    localparam int HOLD_W = (LAP_HOLD_CYCLES > 0) ? $clog2(LAP_HOLD_CYCLES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LAP_HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // ---------------------------------------------------------------
    // Button conditioning: bit 0 start, 1 stop, 2 lap, 3 clear
    // ---------------------------------------------------------------
    logic [3:0]       btn_raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       press;
    logic [DEB_W-1:0] stab_cnt [4];

    assign btn_raw = {btn_clear, btn_lap, btn_stop, btn_start};

    // The press pulse is registered on the same edge the debounced level
    // flips, so the FSM sees it one cycle before its outputs update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == DEB_LAST) begin
                    stab_cnt[i] <= '0;
                    deb[i]      <= sync2[i];
                    press[i]    <= sync2[i];
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    logic ev_start, ev_stop, ev_lap, ev_clear;
    assign ev_start = press[0];
    assign ev_stop  = press[1];
    assign ev_lap   = press[2];
    assign ev_clear = press[3];

    // ---------------------------------------------------------------
    // Control FSM, tick divider and lap hold counter
    // ---------------------------------------------------------------
    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tick;
    logic              count_en_d, count_clear_d, lap_capture_d, show_lap_d, running_d;

    assign tick = (state_q == S_RUN) && (div_q == DIV_LAST);

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        hold_d        = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
        count_en_d    = 1'b0;
        count_clear_d = 1'b0;
        lap_capture_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ev_clear) begin
                    count_clear_d = 1'b1;
                end else if (ev_start) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (ev_clear) begin
                    count_clear_d = 1'b1;
                    div_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    if (tick) begin
                        if ((STOP_AT_MAX != 0) && count_at_max) begin
                            state_d = S_PAUSE;
                        end else begin
                            count_en_d = 1'b1;
                        end
                    end
                    // A stop coinciding with a tick keeps the tick (divider
                    // wraps); otherwise the divider is frozen where it stands.
                    if (ev_stop) begin
                        state_d = S_PAUSE;
                        if (!tick) begin
                            div_d = div_q;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (ev_clear) begin
                    count_clear_d = 1'b1;
                    div_d         = '0;
                    state_d       = S_IDLE;
                end else if (ev_start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase

        if (ev_clear) begin
            hold_d = '0;
        end else if (ev_lap && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
            hold_d        = HOLD_LOAD;
            lap_capture_d = 1'b1;
        end

        show_lap_d = (hold_d != '0);
        running_d  = (state_d == S_RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            hold_q      <= '0;
            count_en    <= 1'b0;
            count_clear <= 1'b0;
            lap_capture <= 1'b0;
            show_lap    <= 1'b0;
            running     <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            count_en    <= count_en_d;
            count_clear <= count_clear_d;
            lap_capture <= lap_capture_d;
            show_lap    <= show_lap_d;
            running     <= running_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4,
//   LAP_HOLD_CYCLES=50. Two instances share all inputs: u_dut wraps at max,
//   u_max stops at max. Edge numbers count CLK rising edges after the most
//   recent reset release; a press first sampled at edge N acts at edge N+6.
module tb_stopwatch_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       count_at_max = 1'b0;

    logic       count_en, count_clear, lap_capture, show_lap, running;
    logic [1:0] state;
    logic       m_count_en, m_count_clear, m_lap_capture, m_show_lap, m_running;
    logic [1:0] m_state;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          edge_no = 0;

    stopwatch_ctrl #(
        .TICK_DIV(10),
        .DEBOUNCE_CYCLES(4),
        .LAP_HOLD_CYCLES(50),
        .STOP_AT_MAX(0)
    ) u_dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_lap(btn_lap),
        .btn_clear(btn_clear),
        .count_at_max(count_at_max),
        .count_en(count_en),
        .count_clear(count_clear),
        .lap_capture(lap_capture),
        .show_lap(show_lap),
        .running(running),
        .state(state)
    );

    stopwatch_ctrl #(
        .TICK_DIV(10),
        .DEBOUNCE_CYCLES(4),
        .LAP_HOLD_CYCLES(50),
        .STOP_AT_MAX(1)
    ) u_max (
        .CLK(CLK),
        .RST_N(RST_N),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_lap(btn_lap),
        .btn_clear(btn_clear),
        .count_at_max(count_at_max),
        .count_en(m_count_en),
        .count_clear(m_count_clear),
        .lap_capture(m_lap_capture),
        .show_lap(m_show_lap),
        .running(m_running),
        .state(m_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        edge_no++;
    endtask

    initial begin
        logic [1:0] exp_st;

        // Reset values, checked before any clock edge
        #2;
        check("rst_state", 32'(state), 32'(2'b00));
        check("rst_running", 32'(running), 32'(1'b0));
        check("rst_count_en", 32'(count_en), 32'(1'b0));
        check("rst_count_clear", 32'(count_clear), 32'(1'b0));
        check("rst_lap_capture", 32'(lap_capture), 32'(1'b0));
        check("rst_show_lap", 32'(show_lap), 32'(1'b0));
        repeat (3) step();
        RST_N   = 1'b1;
        edge_no = 0;

        // Start held from edge 1: RUN at 7, count_en at 17/27/37.
        // Stop first sampled at 38 -> acts in the cycle where divider = 6.
        btn_start = 1'b1;
        for (int e = 1; e <= 43; e++) begin
            step();
            check("a_running", 32'(running), 32'(edge_no >= 7));
            check("a_state", 32'(state), (edge_no >= 7) ? 32'd1 : 32'd0);
            check("a_count_en", 32'(count_en),
                  32'(edge_no == 17 || edge_no == 27 || edge_no == 37));
            check("a_count_clear", 32'(count_clear), 32'(1'b0));
            if (edge_no == 7) check("a_max_state", 32'(m_state), 32'd1);
            if (edge_no == 20) btn_start = 1'b0;
            if (edge_no == 37) btn_stop = 1'b1;
        end

        // PAUSE from edge 44, no strobes
        for (int e = 44; e <= 59; e++) begin
            step();
            check("p_state", 32'(state), 32'd2);
            check("p_running", 32'(running), 32'(1'b0));
            check("p_count_en", 32'(count_en), 32'(1'b0));
            if (edge_no == 48) btn_stop = 1'b0;
            if (edge_no == 59) btn_start = 1'b1;
        end

        // Resume at 66 from divider 6 -> count_en at 70, next at 80
        for (int e = 60; e <= 79; e++) begin
            step();
            exp_st = (edge_no >= 66) ? 2'd1 : 2'd2;
            check("r_state", 32'(state), 32'(exp_st));
            check("r_max_state", 32'(m_state), 32'(exp_st));
            check("r_count_en", 32'(count_en), 32'(edge_no == 70));
            if (edge_no == 68) btn_start = 1'b0;
            if (edge_no == 72) count_at_max = 1'b1;
        end

        // Tick at 80 with counter at max
        step();
        check("wrap_count_en", 32'(count_en), 32'(1'b1));
        check("wrap_state", 32'(state), 32'd1);
        check("stopmax_count_en", 32'(m_count_en), 32'(1'b0));
        check("stopmax_state", 32'(m_state), 32'd2);
        check("stopmax_running", 32'(m_running), 32'(1'b0));
        count_at_max = 1'b0;

        // Lap in RUN: sampled from 82, capture at 88, show_lap 88..137
        step();
        btn_lap = 1'b1;
        for (int e = 82; e <= 150; e++) begin
            step();
            if (edge_no <= 139) begin
                check("lap_capture", 32'(lap_capture), 32'(edge_no == 88));
                check("lap_show", 32'(show_lap), 32'(edge_no >= 88 && edge_no <= 137));
            end
            if (edge_no == 90) btn_lap = 1'b0;
            if (edge_no == 140) btn_lap = 1'b1;
            if (edge_no == 148) btn_lap = 1'b0;
        end

        // Second lap captured at 147; reset mid-RUN, mid-hold
        check("pre_rst_show_lap", 32'(show_lap), 32'(1'b1));
        check("pre_rst_running", 32'(running), 32'(1'b1));
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_running", 32'(running), 32'(1'b0));
        check("arst_show_lap", 32'(show_lap), 32'(1'b0));
        check("arst_count_en", 32'(count_en), 32'(1'b0));
        check("arst_count_clear", 32'(count_clear), 32'(1'b0));
        check("arst_lap_capture", 32'(lap_capture), 32'(1'b0));
        check("arst_max_state", 32'(m_state), 32'd0);
        repeat (2) step();
        RST_N   = 1'b1;
        edge_no = 0;

        // After reset: lap in IDLE (ignored), start glitching (rejected),
        // real start sampled from 31 -> RUN at 37; stop sampled from 41 acts
        // on the tick cycle -> count_en and PAUSE both at 47; lap+clear
        // sampled from 53 -> clear at 59, lap suppressed.
        btn_lap = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            step();
            if (edge_no >= 59)      exp_st = 2'd0;
            else if (edge_no >= 47) exp_st = 2'd2;
            else if (edge_no >= 37) exp_st = 2'd1;
            else                    exp_st = 2'd0;
            check("b_state", 32'(state), 32'(exp_st));
            check("b_max_state", 32'(m_state), 32'(exp_st));
            check("b_running", 32'(running), 32'(exp_st == 2'd1));
            check("b_count_en", 32'(count_en), 32'(edge_no == 47));
            check("b_count_clear", 32'(count_clear), 32'(edge_no == 59));
            check("b_lap_capture", 32'(lap_capture), 32'(1'b0));
            check("b_show_lap", 32'(show_lap), 32'(1'b0));
            case (edge_no)
                10: btn_lap = 1'b0;
                12: btn_start = 1'b1;
                14: btn_start = 1'b0;
                16: btn_start = 1'b1;
                18: btn_start = 1'b0;
                20: btn_start = 1'b1;
                22: btn_start = 1'b0;
                30: btn_start = 1'b1;
                40: begin
                    btn_start = 1'b0;
                    btn_stop  = 1'b1;
                end
                50: btn_stop = 1'b0;
                52: begin
                    btn_lap   = 1'b1;
                    btn_clear = 1'b1;
                end
                62: begin
                    btn_lap   = 1'b0;
                    btn_clear = 1'b0;
                end
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
